// File: rtl/st7789_pkg.sv
// Shared types and constants for the ST7789 window scheduler: opcodes, DC encodings,
// FSM states, window record and the CASET/RASET/RAMWR byte table.
package st7789_pkg;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] RASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [2:0] {IDLE, CMD, PRD, PHI, PLO} state_t;

    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] x1;
        logic [7:0] y1;
    } win_t;

    // Byte idx (0..10) of the address-window preamble, as {DC, byte}.
    function automatic logic [8:0] cmd_byte(input win_t w, input logic [3:0] idx,
                                            input logic [15:0] col_ofs,
                                            input logic [15:0] row_ofs);
        logic [15:0] xs, xe, ys, ye;
        xs = {8'h00, w.x0} + col_ofs;
        xe = {8'h00, w.x1} + col_ofs;
        ys = {8'h00, w.y0} + row_ofs;
        ye = {8'h00, w.y1} + row_ofs;
        case (idx)
            4'd0:    cmd_byte = {DC_CMD, CASET};
            4'd1:    cmd_byte = {DC_DATA, xs[15:8]};
            4'd2:    cmd_byte = {DC_DATA, xs[7:0]};
            4'd3:    cmd_byte = {DC_DATA, xe[15:8]};
            4'd4:    cmd_byte = {DC_DATA, xe[7:0]};
            4'd5:    cmd_byte = {DC_CMD, RASET};
            4'd6:    cmd_byte = {DC_DATA, ys[15:8]};
            4'd7:    cmd_byte = {DC_DATA, ys[7:0]};
            4'd8:    cmd_byte = {DC_DATA, ye[15:8]};
            4'd9:    cmd_byte = {DC_DATA, ye[7:0]};
            default: cmd_byte = {DC_CMD, RAMWR};
        endcase
    endfunction

endpackage

// File: rtl/st7789_win_sched_if.sv
// Bundle of request, vmem and SPI-byte signals around the window scheduler.
// master = drawing logic / memory / SPI side, slave = the scheduler.
interface st7789_win_sched_if;
    logic        w_req_valid;
    logic [7:0]  w_req_x0;
    logic [7:0]  w_req_y0;
    logic [7:0]  w_req_x1;
    logic [7:0]  w_req_y1;
    logic        w_req_ready;
    logic [15:0] w_raddr;
    logic [15:0] w_rdata;
    logic        w_spi_en;
    logic [8:0]  w_spi_data;
    logic        w_spi_busy;
    logic        w_active;
    logic        w_done;
    logic        w_drop;

    modport master (
        output w_req_valid, w_req_x0, w_req_y0, w_req_x1, w_req_y1, w_rdata, w_spi_busy,
        input  w_req_ready, w_raddr, w_spi_en, w_spi_data, w_active, w_done, w_drop
    );

    modport slave (
        input  w_req_valid, w_req_x0, w_req_y0, w_req_x1, w_req_y1, w_rdata, w_spi_busy,
        output w_req_ready, w_raddr, w_spi_en, w_spi_data, w_active, w_done, w_drop
    );
endinterface

// File: rtl/st7789_req_slot.sv
// One-entry pending window: clamps x1/y1, rejects empty windows, holds the request.
// ST7789_WIN_MERGE_EN: slot always accepts and grows into the bounding box of queued requests.
module st7789_req_slot
    import st7789_pkg::*;
#(
    parameter int H_RES = 240,
    parameter int V_RES = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [7:0] x0,
    input  logic [7:0] y0,
    input  logic [7:0] x1,
    input  logic [7:0] y1,
    input  logic       take,
    output logic       ready,
    output logic       full,
    output win_t       win,
    output logic       drop
);
    localparam logic [7:0] XMAX = 8'(H_RES - 1);
    localparam logic [7:0] YMAX = 8'(V_RES - 1);

    win_t cand;
    logic empty;

    always_comb begin
        cand.x0 = x0;
        cand.y0 = y0;
        cand.x1 = (x1 > XMAX) ? XMAX : x1;
        cand.y1 = (y1 > YMAX) ? YMAX : y1;
        empty   = (cand.x0 > cand.x1) || (cand.y0 > cand.y1);
    end

`ifdef ST7789_WIN_MERGE_EN
    function automatic win_t bbox(input win_t a, input win_t b);
        win_t r;
        r.x0 = (a.x0 < b.x0) ? a.x0 : b.x0;
        r.y0 = (a.y0 < b.y0) ? a.y0 : b.y0;
        r.x1 = (a.x1 > b.x1) ? a.x1 : b.x1;
        r.y1 = (a.y1 > b.y1) ? a.y1 : b.y1;
        return r;
    endfunction

    assign ready = 1'b1;

    // A same-cycle launch reads the old contents, so the newcomer refills rather than merges.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            drop <= 1'b0;
        end else begin
            drop <= req_valid && empty;
            if (req_valid && !empty) begin
                full <= 1'b1;
                win  <= (full && !take) ? bbox(win, cand) : cand;
            end else if (take) begin
                full <= 1'b0;
            end
        end
    end
`else
    assign ready = !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            drop <= 1'b0;
        end else begin
            drop <= req_valid && ready && empty;
            if (req_valid && ready && !empty) begin
                full <= 1'b1;
                win  <= cand;
            end else if (take) begin
                full <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/st7789_win_sched.sv
// ST7789 window refresh scheduler: preamble, then vmem pixels as two SPI bytes each.
// Optional ST7789_WIN_MERGE_EN merges queued requests (see st7789_req_slot).
module st7789_win_sched
    import st7789_pkg::*;
#(
    parameter int          H_RES   = 240,
    parameter int          V_RES   = 240,
    parameter int          RD_LAT  = 2,
    parameter logic [15:0] COL_OFS = 16'd0,
    parameter logic [15:0] ROW_OFS = 16'd0
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    st7789_win_sched_if.slave    bus
);
    localparam int LW = $clog2(RD_LAT + 1) + 1;

    state_t         state;
    logic           spi_en;
    logic [8:0]     spi_data;
    logic [15:0]    raddr;
    logic           active;
    logic           done;
    win_t           cur;
    win_t           slot_win;
    logic [7:0]     x;
    logic [7:0]     y;
    logic [3:0]     cnt;
    logic [LW-1:0]  lat;
    logic [15:0]    pix;
    logic           slot_full;
    logic           slot_ready;
    logic           slot_drop;
    logic           take;
    logic           can_send;

    assign take     = (state == IDLE) && slot_full;
    // Never strobe back-to-back: the sender may not have raised busy yet.
    assign can_send = !bus.w_spi_busy && !spi_en;

    st7789_req_slot #(.H_RES(H_RES), .V_RES(V_RES)) u_slot (
        .clk       (w_clk),
        .rst       (w_rst),
        .req_valid (bus.w_req_valid),
        .x0        (bus.w_req_x0),
        .y0        (bus.w_req_y0),
        .x1        (bus.w_req_x1),
        .y1        (bus.w_req_y1),
        .take      (take),
        .ready     (slot_ready),
        .full      (slot_full),
        .win       (slot_win),
        .drop      (slot_drop)
    );

    always_ff @(posedge w_clk) begin
        spi_en <= 1'b0;
        done   <= 1'b0;
        if (w_rst) begin
            state    <= IDLE;
            spi_data <= '0;
            raddr    <= '0;
            active   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    active <= slot_full;
                    if (slot_full) begin
                        cur   <= slot_win;
                        x     <= slot_win.x0;
                        y     <= slot_win.y0;
                        cnt   <= '0;
                        state <= CMD;
                    end
                end
                CMD: if (can_send) begin
                    spi_en   <= 1'b1;
                    spi_data <= cmd_byte(cur, cnt, COL_OFS, ROW_OFS);
                    if (cnt == 4'd10) begin
                        raddr <= {y, x};
                        lat   <= '0;
                        state <= PRD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                PRD: begin
                    if (lat == LW'(RD_LAT)) begin
                        pix   <= bus.w_rdata;
                        state <= PHI;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                PHI: if (can_send) begin
                    spi_en   <= 1'b1;
                    spi_data <= {DC_DATA, pix[15:8]};
                    state    <= PLO;
                end
                PLO: if (can_send) begin
                    spi_en   <= 1'b1;
                    spi_data <= {DC_DATA, pix[7:0]};
                    lat      <= '0;
                    if (x == cur.x1) begin
                        if (y == cur.y1) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            x     <= cur.x0;
                            y     <= y + 8'd1;
                            raddr <= {y + 8'd1, cur.x0};
                            state <= PRD;
                        end
                    end else begin
                        x     <= x + 8'd1;
                        raddr <= {y, x + 8'd1};
                        state <= PRD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.w_req_ready = slot_ready;
    assign bus.w_raddr     = raddr;
    assign bus.w_spi_en    = spi_en;
    assign bus.w_spi_data  = spi_data;
    assign bus.w_active    = active;
    assign bus.w_done      = done;
    assign bus.w_drop      = slot_drop;

endmodule

// File: tb/tb_st7789_win_sched.sv
// Scoreboard bench for st7789_win_sched: a raster model queues expected SPI bytes per
// accepted window; a monitor pops and compares on every byte strobe.
module tb_st7789_win_sched;
    localparam int          RDL  = 2;
    localparam logic [15:0] COLO = 16'd0;
    localparam logic [15:0] ROWO = 16'd0;

    typedef struct {
        logic [8:0] b;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    st7789_win_sched_if bus();

    st7789_win_sched #(
        .H_RES(240), .V_RES(240), .RD_LAT(RDL), .COL_OFS(COLO), .ROW_OFS(ROWO)
    ) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   drops_exp = 0;
    int   drops_seen = 0;
    int   busy_min = 1;
    int   busy_max = 1;
    int   bcnt = 0;
    logic prev_en = 1'b0;
    logic prev_busy = 1'b0;
    logic [15:0] rd_p [RDL];

    function automatic logic [15:0] vmem(input logic [15:0] a);
        if (a == 16'h0705) return 16'hABCD;
        return (a * 16'd40503) ^ 16'h1234;
    endfunction

    // vmem with RD_LAT cycles from address to data
    always @(posedge clk) begin
        rd_p[0] <= vmem(bus.w_raddr);
        for (int i = 1; i < RDL; i++) rd_p[i] <= rd_p[i-1];
    end
    assign bus.w_rdata = rd_p[RDL-1];

    // SPI sender: busy during the strobe and for a random number of cycles after
    always @(posedge clk) begin
        if (bus.w_spi_en) bcnt <= int'($urandom_range(busy_max, busy_min)) - 1;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign bus.w_spi_busy = bus.w_spi_en || (bcnt != 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [8:0] b, input bit l);
        exp_t t;
        t.b = b;
        t.last = l;
        exp_q.push_back(t);
    endtask

    // Reference: byte stream of a window; limit>=0 truncates to that many pixels.
    task automatic model_window(input int x0, input int y0, input int x1, input int y1,
                                input int limit);
        int cx1, cy1, n;
        logic [15:0] xs, xe, ys, ye, p;
        cx1 = (x1 > 239) ? 239 : x1;
        cy1 = (y1 > 239) ? 239 : y1;
        if (x0 > cx1 || y0 > cy1) begin
            drops_exp++;
            return;
        end
        xs = 16'(x0) + COLO;
        xe = 16'(cx1) + COLO;
        ys = 16'(y0) + ROWO;
        ye = 16'(cy1) + ROWO;
        push(9'h02A, 0);
        push({1'b1, xs[15:8]}, 0); push({1'b1, xs[7:0]}, 0);
        push({1'b1, xe[15:8]}, 0); push({1'b1, xe[7:0]}, 0);
        push(9'h02B, 0);
        push({1'b1, ys[15:8]}, 0); push({1'b1, ys[7:0]}, 0);
        push({1'b1, ye[15:8]}, 0); push({1'b1, ye[7:0]}, 0);
        push(9'h02C, 0);
        n = 0;
        for (int y = y0; y <= cy1; y++) begin
            for (int x = x0; x <= cx1; x++) begin
                if (limit >= 0 && n >= limit) return;
                p = vmem({8'(y), 8'(x)});
                push({1'b1, p[15:8]}, 0);
                push({1'b1, p[7:0]}, (limit < 0) && (x == cx1) && (y == cy1));
                n++;
            end
        end
    endtask

    task automatic send_req(input int x0, input int y0, input int x1, input int y1,
                            input int limit, input bit model);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.w_req_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (bus.w_req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: ready %0b required 1", bus.w_req_ready);
            return;
        end
        bus.w_req_valid = 1'b1;
        bus.w_req_x0 = 8'(x0);
        bus.w_req_y0 = 8'(y0);
        bus.w_req_x1 = 8'(x1);
        bus.w_req_y1 = 8'(y1);
        if (model) model_window(x0, y0, x1, y1, limit);
        @(negedge clk);
        bus.w_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.w_active || !bus.w_req_ready) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d bytes still expected", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every byte strobe is checked against the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (bus.w_spi_en) begin
                chk("spi_gap", 32'(prev_en), 32'd0);
                chk("spi_busy_at_issue", 32'(prev_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %03h expected none", bus.w_spi_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("spi_byte", 32'(bus.w_spi_data), 32'(mon_e.b));
                    chk("done_flag", 32'(bus.w_done), 32'(mon_e.last));
                end
            end else if (bus.w_done) begin
                checks++;
                errors++;
                $display("FAIL done_without_byte: done 1 required 0");
            end
            if (bus.w_drop) drops_seen++;
            prev_en   = bus.w_spi_en;
            prev_busy = bus.w_spi_busy;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int rx0, ry0, rx1, ry1, n;

    initial begin
        bus.w_req_valid = 1'b0;
        bus.w_req_x0 = '0;
        bus.w_req_y0 = '0;
        bus.w_req_x1 = '0;
        bus.w_req_y1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_spi_en", 32'(bus.w_spi_en), 32'd0);
        chk("rst_spi_data", 32'(bus.w_spi_data), 32'd0);
        chk("rst_raddr", 32'(bus.w_raddr), 32'd0);
        chk("rst_active", 32'(bus.w_active), 32'd0);
        chk("rst_done", 32'(bus.w_done), 32'd0);
        chk("rst_drop", 32'(bus.w_drop), 32'd0);
        chk("rst_ready", 32'(bus.w_req_ready), 32'd1);
        rst = 1'b0;

        send_req(5, 7, 5, 7, -1, 1);
        wait_idle();

        send_req(0, 0, 1, 1, -1, 1);
        send_req(10, 10, 10, 10, -1, 1);
        @(negedge clk);
`ifndef ST7789_WIN_MERGE_EN
        chk("ready_while_pending", 32'(bus.w_req_ready), 32'd0);
`endif
        chk("active_streaming", 32'(bus.w_active), 32'd1);
        wait_idle();

        send_req(230, 0, 250, 9, -1, 1);
        wait_idle();
        send_req(20, 0, 10, 5, -1, 1);
        wait_idle();
        chk("drop_count", 32'(drops_seen), 32'(drops_exp));

        busy_min = 1;
        busy_max = 4;
        for (int i = 0; i < 16; i++) begin
            rx0 = int'($urandom_range(0, 239));
            ry0 = int'($urandom_range(0, 239));
            rx1 = rx0 + int'($urandom_range(0, 6));
            ry1 = ry0 + int'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0 && rx0 > 0) rx1 = rx0 - 1;
            if ($urandom_range(0, 7) == 0 && ry0 > 0) ry1 = ry0 - 1;
            repeat ($urandom_range(0, 20)) @(negedge clk);
`ifdef ST7789_WIN_MERGE_EN
            wait_idle();
`endif
            send_req(rx0, ry0, rx1, ry1, -1, 1);
        end
        wait_idle();

        // full screen with a slow sender, abandoned by reset while waiting to send a pixel
        busy_min = 19;
        busy_max = 19;
        send_req(0, 0, 239, 239, 0, 1);
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("header_bytes_left", 32'(exp_q.size()), 32'd0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midwin_rst_spi_en", 32'(bus.w_spi_en), 32'd0);
        chk("midwin_rst_active", 32'(bus.w_active), 32'd0);
        chk("midwin_rst_ready", 32'(bus.w_req_ready), 32'd1);
        chk("midwin_rst_raddr", 32'(bus.w_raddr), 32'd0);
        rst = 1'b0;
        send_req(5, 7, 5, 7, -1, 1);
        wait_idle();

`ifdef ST7789_WIN_MERGE_EN
        busy_min = 1;
        busy_max = 1;
        send_req(2, 2, 3, 3, -1, 1);
        send_req(0, 5, 1, 6, -1, 0);
        send_req(8, 1, 9, 2, -1, 0);
        chk("merge_ready", 32'(bus.w_req_ready), 32'd1);
        model_window(0, 1, 9, 6, -1);
        wait_idle();
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drop_count_final", 32'(drops_seen), 32'(drops_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
